// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: drives a 4-bit HD44780-style LCD.
// After reset it runs the power-on nibble sequence and the display configuration bytes.
// It then accepts command/data byte writes through a ready/write handshake.
// All pacing comes from one shared cycle counter; the busy flag is never read.
// Optional macro LCD_LONG_CMD_WAIT_EN: application Clear Display / Return Home
// commands (RS=0, data[7:2]=0) get the long T_CLEAR post-byte wait.
module lcd_init_sequencer #(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SHORT   = 2000,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_NIB     = 50
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_WAIT,
        IDLE,
        HI_SETUP,
        HI_PULSE,
        HI_GAP,
        LO_SETUP,
        LO_PULSE,
        WAIT
    } state_t;

    localparam logic [7:0] CFG_FIRST = 8'h28;

    state_t      state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [19:0] dur;
    logic        done;
    logic [1:0]  step, step_nxt;
    logic [1:0]  cfg_idx, cfg_idx_nxt;
    logic        in_cfg, in_cfg_nxt;
    logic [7:0]  cur_byte, byte_nxt;
    logic        cur_long, long_nxt;
    logic        ready_q, ready_nxt;
    logic        e_q, e_nxt;
    logic        rs_q, rs_nxt;
    logic [3:0]  data_q, data_nxt;
    logic [7:0]  cfg_next_byte;
    logic        app_long;

    // Nibble sent at each power-on step (DB7..DB4).
    function automatic logic [3:0] init_nibble(input logic [1:0] s);
        return (s == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Wait that follows each power-on nibble.
    function automatic logic [19:0] init_wait(input logic [1:0] s);
        case (s)
            2'd0:    return 20'(T_INIT1);
            2'd1:    return 20'(T_INIT2);
            default: return 20'(T_SHORT);
        endcase
    endfunction

    // Configuration bytes: function set, entry mode, display on, clear.
    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    assign cfg_next_byte = cfg_byte(cfg_idx + 2'd1);

`ifdef LCD_LONG_CMD_WAIT_EN
    assign app_long = !iRS && (iData[7:2] == 6'd0);
`else
    assign app_long = 1'b0;
`endif

    // Next-state, counter and registered-output logic for the whole sequencer.
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        cfg_idx_nxt = cfg_idx;
        in_cfg_nxt  = in_cfg;
        byte_nxt    = cur_byte;
        long_nxt    = cur_long;
        rs_nxt      = rs_q;
        data_nxt    = data_q;
        dur         = 20'd1;

        case (state)
            PWR_WAIT:   dur = 20'(T_POWERON);
            INIT_SETUP: dur = 20'd1;
            INIT_PULSE: dur = 20'(T_EN);
            INIT_WAIT:  dur = init_wait(step);
            HI_SETUP:   dur = 20'd1;
            HI_PULSE:   dur = 20'(T_EN);
            HI_GAP:     dur = 20'(T_NIB);
            LO_SETUP:   dur = 20'd1;
            LO_PULSE:   dur = 20'(T_EN);
            WAIT:       dur = cur_long ? 20'(T_CLEAR) : 20'(T_SHORT);
            default:    dur = 20'd1;
        endcase
        done = (cnt == dur - 20'd1);

        case (state)
            PWR_WAIT: begin
                if (done) begin
                    state_nxt = INIT_SETUP;
                    step_nxt  = 2'd0;
                    rs_nxt    = 1'b0;
                    data_nxt  = init_nibble(2'd0);
                end
            end
            INIT_SETUP: begin
                if (done) state_nxt = INIT_PULSE;
            end
            INIT_PULSE: begin
                if (done) state_nxt = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (done) begin
                    if (step != 2'd3) begin
                        step_nxt  = step + 2'd1;
                        data_nxt  = init_nibble(step + 2'd1);
                        state_nxt = INIT_SETUP;
                    end else begin
                        in_cfg_nxt  = 1'b1;
                        cfg_idx_nxt = 2'd0;
                        byte_nxt    = CFG_FIRST;
                        long_nxt    = 1'b0;
                        rs_nxt      = 1'b0;
                        data_nxt    = CFG_FIRST[7:4];
                        state_nxt   = HI_SETUP;
                    end
                end
            end
            IDLE: begin
                if (iWrite) begin
                    byte_nxt  = iData;
                    rs_nxt    = iRS;
                    long_nxt  = app_long;
                    data_nxt  = iData[7:4];
                    state_nxt = HI_SETUP;
                end
            end
            HI_SETUP: begin
                if (done) state_nxt = HI_PULSE;
            end
            HI_PULSE: begin
                if (done) state_nxt = HI_GAP;
            end
            HI_GAP: begin
                if (done) begin
                    data_nxt  = cur_byte[3:0];
                    state_nxt = LO_SETUP;
                end
            end
            LO_SETUP: begin
                if (done) state_nxt = LO_PULSE;
            end
            LO_PULSE: begin
                if (done) state_nxt = WAIT;
            end
            WAIT: begin
                if (done) begin
                    if (in_cfg && (cfg_idx != 2'd3)) begin
                        cfg_idx_nxt = cfg_idx + 2'd1;
                        byte_nxt    = cfg_next_byte;
                        long_nxt    = (cfg_idx == 2'd2);
                        data_nxt    = cfg_next_byte[7:4];
                        state_nxt   = HI_SETUP;
                    end else begin
                        in_cfg_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = PWR_WAIT;
        endcase

        cnt_nxt   = (done || (state == IDLE)) ? 20'd0 : cnt + 20'd1;
        e_nxt     = (state_nxt == INIT_PULSE) || (state_nxt == HI_PULSE) ||
                    (state_nxt == LO_PULSE);
        ready_nxt = (state_nxt == IDLE);
    end

    // State, counter and output registers; reset drops E at once and restarts power-on.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= PWR_WAIT;
            cnt      <= 20'd0;
            step     <= 2'd0;
            cfg_idx  <= 2'd0;
            in_cfg   <= 1'b0;
            cur_byte <= 8'd0;
            cur_long <= 1'b0;
            ready_q  <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 4'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            step     <= step_nxt;
            cfg_idx  <= cfg_idx_nxt;
            in_cfg   <= in_cfg_nxt;
            cur_byte <= byte_nxt;
            cur_long <= long_nxt;
            ready_q  <= ready_nxt;
            e_q      <= e_nxt;
            rs_q     <= rs_nxt;
            data_q   <= data_nxt;
        end
    end

    assign oReady    = ready_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = rs_q;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = data_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb_lcd_init_sequencer: self-checking bench for lcd_init_sequencer.
// A negedge monitor records every E pulse (RS, nibble, width) and counts hold violations.
// The expected pulse streams and latencies come from the timing rules as plain arithmetic.
module tb_lcd_init_sequencer;

    localparam int T_POWERON = 100;
    localparam int T_INIT1   = 40;
    localparam int T_INIT2   = 20;
    localparam int T_SHORT   = 10;
    localparam int T_CLEAR   = 30;
    localparam int T_EN      = 3;
    localparam int T_NIB     = 5;
`ifdef LCD_LONG_CMD_WAIT_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int LAT_SHORT   = 2 + 2 * T_EN + T_NIB + T_SHORT;
    localparam int LAT_CLEAR   = 2 + 2 * T_EN + T_NIB + T_CLEAR;
    localparam int LAT_HOME    = LONG_EN ? LAT_CLEAR : LAT_SHORT;
    localparam int INIT_CYCLES = T_POWERON + T_INIT1 + T_INIT2 + 2 * T_SHORT +
                                 4 * (1 + T_EN) + 3 * LAT_SHORT + LAT_CLEAR;
    localparam int BUDGET = 5000;

    typedef struct {
        logic rs;
        logic [3:0] nib;
        int width;
    } pulse_t;

    typedef struct {
        logic rs;
        logic [7:0] data;
        logic [3:0] exp_hi;
        logic [3:0] exp_lo;
        int exp_lat;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iWrite;
    logic       iRS;
    logic [7:0] iData;
    logic       oReady;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_Data;

    pulse_t     pulses[$];
    pulse_t     cur;
    logic       prev_e = 1'b0;
    logic       prev_rs = 1'b0;
    logic [3:0] prev_data = 4'd0;
    int         hold_viol = 0;
    int         rd_idx = 0;
    int         compared = 0;
    int         mismatched = 0;

    lcd_init_sequencer #(
        .T_POWERON(T_POWERON),
        .T_INIT1  (T_INIT1),
        .T_INIT2  (T_INIT2),
        .T_SHORT  (T_SHORT),
        .T_CLEAR  (T_CLEAR),
        .T_EN     (T_EN),
        .T_NIB    (T_NIB)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iWrite   (iWrite),
        .iRS      (iRS),
        .iData    (iData),
        .oReady   (oReady),
        .oLCD_E   (oLCD_E),
        .oLCD_RS  (oLCD_RS),
        .oLCD_RW  (oLCD_RW),
        .oLCD_Data(oLCD_Data)
    );

    always #5 Clock = ~Clock;

    // Record each E pulse and flag RS/data movement during or just before a pulse.
    always @(negedge Clock) begin
        if (Reset) begin
            prev_e = 1'b0;
        end else begin
            if (oLCD_E && !prev_e) begin
                cur.rs    = oLCD_RS;
                cur.nib   = oLCD_Data;
                cur.width = 1;
                if (oLCD_RS !== prev_rs || oLCD_Data !== prev_data) hold_viol++;
            end else if (oLCD_E && prev_e) begin
                cur.width++;
                if (oLCD_RS !== cur.rs || oLCD_Data !== cur.nib) hold_viol++;
            end else if (!oLCD_E && prev_e) begin
                pulses.push_back(cur);
            end
            prev_e = oLCD_E;
        end
        prev_rs   = oLCD_RS;
        prev_data = oLCD_Data;
    end

    // Give up loudly if the run never reaches its summary.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkNextPulse(input string name, input logic rs, input logic [3:0] nib);
        if (rd_idx < pulses.size()) begin
            checkOutput({name, "_rs"}, int'(pulses[rd_idx].rs), int'(rs));
            checkOutput({name, "_nib"}, int'(pulses[rd_idx].nib), int'(nib));
            checkOutput({name, "_width"}, pulses[rd_idx].width, T_EN);
            rd_idx++;
        end else begin
            checkOutput({name, "_present"}, pulses.size(), rd_idx + 1);
        end
    endtask

    task automatic expectByte(input string name, input logic rs, input logic [7:0] data);
        checkNextPulse({name, "_hi"}, rs, data[7:4]);
        checkNextPulse({name, "_lo"}, rs, data[3:0]);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, int'(oReady), 0);
        checkOutput({tag, "_e"}, int'(oLCD_E), 0);
        checkOutput({tag, "_rs"}, int'(oLCD_RS), 0);
        checkOutput({tag, "_rw"}, int'(oLCD_RW), 0);
        checkOutput({tag, "_data"}, int'(oLCD_Data), 0);
    endtask

    // Release reset and check the full power-on plus configuration stream and its duration.
    task automatic checkInit(input string tag);
        int n;
        logic [7:0] cfg[4];
        logic [3:0] init_nibs[4];
        cfg       = '{8'h28, 8'h06, 8'h0C, 8'h01};
        init_nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
        @(negedge Clock);
        rd_idx = pulses.size();
        Reset  = 1'b0;
        n = 0;
        while (!oReady && n < BUDGET) begin
            @(posedge Clock);
            #1;
            n++;
        end
        checkOutput({tag, "_init_cycles"}, n, INIT_CYCLES);
        for (int i = 0; i < 4; i++)
            checkNextPulse($sformatf("%s_init%0d", tag, i), 1'b0, init_nibs[i]);
        for (int i = 0; i < 4; i++)
            expectByte($sformatf("%s_cfg%0d", tag, i), 1'b0, cfg[i]);
        checkOutput({tag, "_init_extra_pulses"}, pulses.size(), rd_idx);
    endtask

    function automatic int modelLatency(input logic rs, input logic [7:0] data);
        int post;
        post = (LONG_EN && !rs && data < 8'd4) ? T_CLEAR : T_SHORT;
        return 2 + 2 * T_EN + T_NIB + post;
    endfunction

    // Issue one write after an idle gap; optionally toggle iWrite randomly while busy.
    task automatic applyStimulus(input logic rs, input logic [7:0] data, input int gap,
                                 input bit spurious, output int lat);
        int k;
        k = 0;
        while (!oReady && k < BUDGET) begin
            @(negedge Clock);
            k++;
        end
        if (!oReady) checkOutput("ready_wait_timeout", 0, 1);
        repeat (gap) @(negedge Clock);
        iRS    = rs;
        iData  = data;
        iWrite = 1'b1;
        @(posedge Clock);
        #1;
        iWrite = 1'b0;
        lat = 0;
        while (!oReady && lat < BUDGET) begin
            if (spurious) begin
                iWrite = ($urandom_range(0, 3) == 0);
                iRS    = 1'($urandom);
                iData  = 8'($urandom);
            end
            @(posedge Clock);
            #1;
            lat++;
        end
        iWrite = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        int lat;
        int k;
        logic rs;
        logic [7:0] data;

        vecs[0] = '{1'b1, 8'h41, 4'h4, 4'h1, LAT_SHORT};
        vecs[1] = '{1'b0, 8'h01, 4'h0, 4'h1, LAT_HOME};
        vecs[2] = '{1'b0, 8'h02, 4'h0, 4'h2, LAT_HOME};
        vecs[3] = '{1'b0, 8'h04, 4'h0, 4'h4, LAT_SHORT};
        vecs[4] = '{1'b1, 8'hFF, 4'hF, 4'hF, LAT_SHORT};
        vecs[5] = '{1'b0, 8'h80, 4'h8, 4'h0, LAT_SHORT};
        vecs[6] = '{1'b0, 8'h03, 4'h0, 4'h3, LAT_HOME};

        Reset  = 1'b1;
        iWrite = 1'b0;
        iRS    = 1'b0;
        iData  = 8'd0;
        repeat (3) @(posedge Clock);
        #1;
        checkResetValues("por");
        checkInit("por");

        // Directed writes from the vector table.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rs, vecs[i].data, 1, 1'b0, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            checkNextPulse($sformatf("vec%0d_hi", i), vecs[i].rs, vecs[i].exp_hi);
            checkNextPulse($sformatf("vec%0d_lo", i), vecs[i].rs, vecs[i].exp_lo);
            checkOutput($sformatf("vec%0d_extra_pulses", i), pulses.size(), rd_idx);
            checkOutput($sformatf("vec%0d_idle_data", i), int'(oLCD_Data), int'(vecs[i].exp_lo));
            checkOutput($sformatf("vec%0d_idle_rs", i), int'(oLCD_RS), int'(vecs[i].rs));
        end

        // Random writes with spurious requests while busy, against the rule-based model.
        for (int i = 0; i < 20; i++) begin
            rs   = 1'($urandom);
            data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            applyStimulus(rs, data, $urandom_range(0, 3), 1'b1, lat);
            checkOutput($sformatf("rnd%0d_latency", i), lat, modelLatency(rs, data));
            expectByte($sformatf("rnd%0d", i), rs, data);
            checkOutput($sformatf("rnd%0d_extra_pulses", i), pulses.size(), rd_idx);
        end

        // Held iWrite: back-to-back writes, each accepted on the first ready cycle.
        k = 0;
        while (!oReady && k < BUDGET) begin
            @(negedge Clock);
            k++;
        end
        @(negedge Clock);
        iRS    = 1'b1;
        iData  = 8'hA5;
        iWrite = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(posedge Clock);
            #1;
            checkOutput($sformatf("held%0d_accept", w), int'(oReady), 0);
            lat = 0;
            while (!oReady && lat < BUDGET) begin
                @(posedge Clock);
                #1;
                lat++;
            end
            checkOutput($sformatf("held%0d_latency", w), lat, LAT_SHORT);
        end
        iWrite = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        checkOutput("held_idle_ready", int'(oReady), 1);
        for (int w = 0; w < 3; w++) expectByte($sformatf("held%0d", w), 1'b1, 8'hA5);
        checkOutput("held_extra_pulses", pulses.size(), rd_idx);

        // Reset in the middle of the high-nibble pulse of a write.
        k = 0;
        while (!oReady && k < BUDGET) begin
            @(negedge Clock);
            k++;
        end
        iRS    = 1'b1;
        iData  = 8'h77;
        iWrite = 1'b1;
        @(posedge Clock);
        #1;
        iWrite = 1'b0;
        k = 0;
        while (!oLCD_E && k < 100) begin
            @(posedge Clock);
            #1;
            k++;
        end
        checkOutput("midpulse_e_seen", int'(oLCD_E), 1);
        #2;
        Reset = 1'b1;
        #1;
        checkResetValues("midpulse");
        repeat (3) @(posedge Clock);
        checkInit("rerun");

        checkOutput("hold_violations", hold_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lcd_init_sequencer.md
# lcd_init_sequencer

Sequencer for a 4-bit HD44780-compatible character LCD: after reset it runs the power-on nibble sequence and display configuration, then accepts byte writes (command or data) from the application through a ready/write handshake. It sits between application logic and the LCD pins and owns all LCD enable-pulse and wait timing. RW is tied low; the LCD busy flag is never read, so all pacing comes from cycle counters.

## Interface
Parameters (all in Clock cycles; defaults assume 50 MHz):
- T_POWERON, 750000, wait after reset before the first init nibble (15 ms)
- T_INIT1, 205000, wait after the first 0x3 nibble (4.1 ms)
- T_INIT2, 5000, wait after the second 0x3 nibble (100 us)
- T_SHORT, 2000, wait after the third 0x3 nibble, the 0x2 nibble, and every byte (40 us)
- T_CLEAR, 82000, wait after the Clear Display command (1.64 ms)
- T_EN, 12, width of the E high pulse
- T_NIB, 50, E-low gap between the high and low nibbles of a byte

Ports:
- Clock  in  1  system clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- iWrite  in  1  write request; sampled only while oReady=1
- iRS  in  1  register select for the request: 0 = command, 1 = data
- iData  in  8  byte to write
- oReady  out  1  high when idle and able to accept a write
- oLCD_E  out  1  LCD enable
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  LCD read/write; constant 0
- oLCD_Data  out  4  LCD data nibble, DB7..DB4

## Operation
- **Reset values:** oReady=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=0. The state machine enters PWR_WAIT and the delay counter clears.
- **Delay counter:** one 20-bit down/up counter shared by all states. Each state loads the counter on entry and exits when the count completes.
- **Power-on sequence** (RS=0 throughout; each step is NIB_SETUP → NIB_PULSE → delay):
  - PWR_WAIT for T_POWERON
  - nibble 0x3, then T_INIT1
  - nibble 0x3, then T_INIT2
  - nibble 0x3, then T_SHORT
  - nibble 0x2, then T_SHORT
- **Configuration bytes** (RS=0, sent with the byte procedure below):
  - 0x28, 0x06, 0x0C: each followed by T_SHORT
  - 0x01 (Clear Display): followed by T_CLEAR
  - Then enter IDLE with oReady=1.
- **Byte procedure:**
  - HI_SETUP: 1 cycle, oLCD_Data=byte[7:4], RS valid, E=0
  - HI_PULSE: T_EN cycles, E=1
  - HI_GAP: T_NIB cycles, E=0, data held
  - LO_SETUP: 1 cycle, oLCD_Data=byte[3:0]
  - LO_PULSE: T_EN cycles, E=1
  - WAIT: post-byte delay, E=0
- **IDLE:** oLCD_Data and oLCD_RS keep their last values. When iWrite=1 at a rising edge, {iRS, iData} is latched, oReady drops, and the byte procedure starts.
- **States:** PWR_WAIT, INIT_SETUP, INIT_PULSE, INIT_WAIT, CFG_*, IDLE, HI_SETUP, HI_PULSE, HI_GAP, LO_SETUP, LO_PULSE, WAIT. An init-step index (0..3) and a config index (0..3) select the nibble or byte and its delay.

## Timing
- **Accept:** the accepting edge is the one where oReady=1 and iWrite=1. oReady is 0 from the next cycle on.
- **Write latency:** oReady returns to 1 exactly 2 + 2·T_EN + T_NIB + Tpost cycles after the accepting edge. With defaults and Tpost=T_SHORT this is 2076.
- **Ignored requests:** iWrite while oReady=0 is ignored. There is no queuing, and a held iWrite is re-accepted in the first cycle oReady is back at 1.
- **Signal stability:** oLCD_E is glitch-free and registered. oLCD_Data and oLCD_RS never change while E=1, and stay stable at least 1 cycle before E rises and T_NIB/Tpost cycles after it falls.
- **Reset mid-operation:** Reset asserted at any time, including mid-pulse, forces E=0 immediately (asynchronously) and restarts the full power-on sequence.
- **Init-to-ready:** the first oReady=1 occurs T_POWERON + T_INIT1 + T_INIT2 + 2·T_SHORT + 4·(1+T_EN) + 3·(byte procedure with T_SHORT) + (byte procedure with T_CLEAR) cycles after Reset deasserts.

## Configuration
- **LCD_LONG_CMD_WAIT_EN defined:** an accepted write with iRS=0 and iData[7:2]=0 (Clear Display or Return Home) uses Tpost=T_CLEAR. All other writes use T_SHORT.
- **LCD_LONG_CMD_WAIT_EN undefined:** every application write uses Tpost=T_SHORT. The application must then pace clear/home commands itself. The configuration-phase 0x01 always waits T_CLEAR, with or without the macro.

## Test plan
All scenarios use simulation parameters T_POWERON=100, T_INIT1=40, T_INIT2=20, T_SHORT=10, T_CLEAR=30, T_EN=3, T_NIB=5.
- **Reset and init:** release Reset → exactly four nibble pulses with data 3,3,3,2 and RS=0, then E pulses carrying bytes 0x28, 0x06, 0x0C, 0x01. oReady rises at the computed init-to-ready cycle and E pulses are exactly 3 cycles wide.
- **Data write:** iWrite=1, iRS=1, iData=0x41 in IDLE → oLCD_Data=4 then 1 with RS=1 during both pulses. oReady returns to 1 after 2+6+5+10=23 cycles.
- **Long command:** with LCD_LONG_CMD_WAIT_EN, write iRS=0, iData=0x01 → latency 43 cycles. Without the macro → latency 23 cycles.
- **Ignored request:** pulse iWrite while oReady=0 → no extra E pulses. Hold iWrite continuously → back-to-back writes, each accepted on the first cycle oReady=1.
- **Reset mid-pulse:** assert Reset during HI_PULSE of a write → oLCD_E=0 before the next edge and all outputs at reset values. After release, the full init sequence repeats.
- **Hold check:** the monitor flags any oLCD_Data or oLCD_RS change while oLCD_E=1 across all scenarios; zero violations are required.
